// File: rtl/fetch_unit.sv
// Instruction fetch: owns the PC, issues single-cycle-latency reads to instruction
// memory and buffers the returned {pc, instr} pairs in a 2-entry FIFO for decode.
module fetch_unit #(
  parameter int                    data_width   = 32,
  parameter logic [data_width-1:0] reset_vector = 32'hBFC00000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  output logic                  imem_req,
  output logic [data_width-1:0] imem_addr,
  input  logic [data_width-1:0] imem_rdata,
  output logic                  instr_valid,
  input  logic                  instr_ready,
  output logic [data_width-1:0] instr_out,
  output logic [data_width-1:0] pc_out,
  input  logic                  redirect,
  input  logic [data_width-1:0] redirect_base,
  input  logic [data_width-1:0] ImmOp,
  output logic                  misaligned
);

  logic [data_width-1:0] pc_q, pc_d;
  logic [data_width-1:0] inflight_pc_q, inflight_pc_d;
  logic [1:0]            count_q, count_d;
  logic                  inflight_q, inflight_d;
  logic                  misaligned_q, misaligned_d;
  logic                  rd_ptr_q, rd_ptr_d;
  logic                  wr_ptr_q, wr_ptr_d;
  logic [data_width-1:0] fifo_pc_q [2];
  logic [data_width-1:0] fifo_pc_d [2];
  logic [data_width-1:0] fifo_instr_q [2];
  logic [data_width-1:0] fifo_instr_d [2];

  logic                  pop;
  logic                  push;
  logic                  drop;
  logic                  issue_ok;
  logic [2:0]            occupancy;
  logic [data_width-1:0] target;

  assign instr_valid = (count_q != 2'd0);
  assign instr_out   = fifo_instr_q[rd_ptr_q];
  assign pc_out      = fifo_pc_q[rd_ptr_q];
  assign misaligned  = misaligned_q;

  assign pop  = instr_valid && instr_ready;
  // A response landing in a redirect cycle belongs to the old path.
  assign drop = redirect;
  assign push = inflight_q && !drop;

  // Entries held plus the one in flight, after this cycle's pop, must leave room.
  assign occupancy = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, pop};
  assign issue_ok  = (occupancy < 3'd2);

  assign imem_req  = rst_n && !redirect && issue_ok;
  assign imem_addr = pc_q;

  assign target = redirect_base + {ImmOp[data_width-2:0], 1'b0};

  always_comb begin
    pc_d          = pc_q;
    inflight_pc_d = inflight_pc_q;
    inflight_d    = 1'b0;
    misaligned_d  = misaligned_q;
    rd_ptr_d      = rd_ptr_q ^ pop;
    wr_ptr_d      = wr_ptr_q;
    count_d       = count_q - {1'b0, pop} + {1'b0, push};
    fifo_pc_d     = fifo_pc_q;
    fifo_instr_d  = fifo_instr_q;

    if (push) begin
      fifo_pc_d[wr_ptr_q]    = inflight_pc_q;
      fifo_instr_d[wr_ptr_q] = imem_rdata;
      wr_ptr_d               = ~wr_ptr_q;
    end

    if (imem_req) begin
      pc_d          = pc_q + 4;
      inflight_d    = 1'b1;
      inflight_pc_d = pc_q;
    end

    if (redirect) begin
      pc_d       = {target[data_width-1:2], 2'b00};
      inflight_d = 1'b0;
      count_d    = 2'd0;
      rd_ptr_d   = 1'b0;
      wr_ptr_d   = 1'b0;
      if (target[1]) misaligned_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_q          <= reset_vector;
      inflight_pc_q <= '0;
      inflight_q    <= 1'b0;
      misaligned_q  <= 1'b0;
      count_q       <= 2'd0;
      rd_ptr_q      <= 1'b0;
      wr_ptr_q      <= 1'b0;
      fifo_pc_q     <= '{default: '0};
      fifo_instr_q  <= '{default: '0};
    end else begin
      pc_q          <= pc_d;
      inflight_pc_q <= inflight_pc_d;
      inflight_q    <= inflight_d;
      misaligned_q  <= misaligned_d;
      count_q       <= count_d;
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
      fifo_pc_q     <= fifo_pc_d;
      fifo_instr_q  <= fifo_instr_d;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: memory returns its own address as the instruction word;
// expected fetch PCs are queued as requests are expected and popped on each handshake.
module tb_fetch_unit;
  localparam logic [31:0] RV = 32'hBFC00000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata = '0;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic [31:0] instr_out;
  logic [31:0] pc_out;
  logic        redirect = 1'b0;
  logic [31:0] redirect_base = '0;
  logic [31:0] ImmOp = '0;
  logic        misaligned;

  int          vecs = 0;
  int          errs = 0;
  logic [31:0] exp_q[$];
  logic [31:0] model_pc;
  logic [31:0] e;

  fetch_unit dut (
    .clk(clk), .rst_n(rst_n), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr_out(instr_out), .pc_out(pc_out), .redirect(redirect),
    .redirect_base(redirect_base), .ImmOp(ImmOp), .misaligned(misaligned)
  );

  always #5 clk = ~clk;

  always @(posedge clk) imem_rdata <= imem_req ? imem_addr : 32'hDEADBEEF;

  task automatic drive(input logic rst_v, input logic rdy, input logic redir,
                       input logic [31:0] base, input logic [31:0] imm);
    @(negedge clk);
    rst_n = rst_v; instr_ready = rdy; redirect = redir;
    redirect_base = base; ImmOp = imm;
    #1;
  endtask

  task automatic test_reset();
    drive(0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0);
    vecs++; if (imem_req !== 1'b0) begin errs++; $display("FAIL reset_req got %b want 0", imem_req); end
    vecs++; if (instr_valid !== 1'b0) begin errs++; $display("FAIL reset_valid got %b want 0", instr_valid); end
    vecs++; if (instr_out !== 32'h0) begin errs++; $display("FAIL reset_instr got %h want 0", instr_out); end
    vecs++; if (pc_out !== 32'h0) begin errs++; $display("FAIL reset_pc got %h want 0", pc_out); end
    vecs++; if (misaligned !== 1'b0) begin errs++; $display("FAIL reset_misaligned got %b want 0", misaligned); end
    exp_q.delete();
    model_pc = RV;
  endtask

  task automatic test_stream();
    for (int k = 0; k < 12; k++) begin
      drive(1, 1, 0, 0, 0);
      vecs++;
      if (imem_req !== 1'b1 || imem_addr !== model_pc) begin
        errs++; $display("FAIL stream_addr k=%0d got req=%b addr=%h want 1 %h", k, imem_req, imem_addr, model_pc);
      end
      vecs++;
      if (instr_valid !== (k >= 2)) begin
        errs++; $display("FAIL stream_valid k=%0d got %b want %b", k, instr_valid, (k >= 2));
      end
      if (instr_valid) begin
        if (exp_q.size() != 0) e = exp_q.pop_front(); else e = 32'hFFFFFFFF;
        vecs++;
        if (pc_out !== e || instr_out !== e) begin
          errs++; $display("FAIL stream_out pc=%h instr=%h want %h", pc_out, instr_out, e);
        end
      end
      exp_q.push_back(model_pc);
      model_pc = model_pc + 4;
    end
  endtask

  task automatic test_backpressure();
    for (int b = 0; b < 5; b++) begin
      drive(1, 0, 0, 0, 0);
      vecs++; if (imem_req !== 1'b0) begin errs++; $display("FAIL bp_req b=%0d got %b want 0", b, imem_req); end
      vecs++;
      if (instr_valid !== 1'b1 || pc_out !== exp_q[0] || dut.count_q > 2'd2) begin
        errs++; $display("FAIL bp_hold b=%0d got valid=%b pc=%h count=%0d want 1 %h <=2", b, instr_valid, pc_out, dut.count_q, exp_q[0]);
      end
    end
    for (int k = 0; k < 8; k++) begin
      drive(1, 1, 0, 0, 0);
      vecs++;
      if (imem_req !== 1'b1 || imem_addr !== model_pc) begin
        errs++; $display("FAIL bp_resume_addr k=%0d got req=%b addr=%h want 1 %h", k, imem_req, imem_addr, model_pc);
      end
      vecs++;
      if (instr_valid !== 1'b1) begin errs++; $display("FAIL bp_resume_valid k=%0d got %b want 1", k, instr_valid); end
      if (instr_valid) begin
        if (exp_q.size() != 0) e = exp_q.pop_front(); else e = 32'hFFFFFFFF;
        vecs++;
        if (pc_out !== e || instr_out !== e) begin
          errs++; $display("FAIL bp_resume_out pc=%h instr=%h want %h", pc_out, instr_out, e);
        end
      end
      exp_q.push_back(model_pc);
      model_pc = model_pc + 4;
    end
  endtask

  task automatic test_redirect();
    drive(1, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0);
    vecs++; if (dut.count_q !== 2'd2) begin errs++; $display("FAIL redir_full count got %0d want 2", dut.count_q); end
    drive(1, 0, 1, 32'hBFC00010, 32'hFFFFFFF8);
    vecs++; if (imem_req !== 1'b0) begin errs++; $display("FAIL redir_req got %b want 0", imem_req); end
    exp_q.delete();
    model_pc = RV;
    for (int k = 0; k < 4; k++) begin
      drive(1, 1, 0, 0, 0);
      vecs++;
      if (imem_req !== 1'b1 || imem_addr !== model_pc) begin
        errs++; $display("FAIL redir_addr k=%0d got req=%b addr=%h want 1 %h", k, imem_req, imem_addr, model_pc);
      end
      vecs++;
      if (instr_valid !== (k >= 2)) begin errs++; $display("FAIL redir_valid k=%0d got %b want %b", k, instr_valid, (k >= 2)); end
      if (instr_valid) begin
        if (exp_q.size() != 0) e = exp_q.pop_front(); else e = 32'hFFFFFFFF;
        vecs++;
        if (pc_out !== e || instr_out !== e) begin
          errs++; $display("FAIL redir_out pc=%h instr=%h want %h", pc_out, instr_out, e);
        end
      end
      exp_q.push_back(model_pc);
      model_pc = model_pc + 4;
    end
  endtask

  task automatic test_redirect_pop();
    drive(1, 1, 1, 32'hBFC00100, 32'h00000040);
    vecs++; if (imem_req !== 1'b0) begin errs++; $display("FAIL rpop_req got %b want 0", imem_req); end
    vecs++;
    if (instr_valid !== 1'b1 || pc_out !== 32'hBFC00008) begin
      errs++; $display("FAIL rpop_head got valid=%b pc=%h want 1 bfc00008", instr_valid, pc_out);
    end
    if (exp_q.size() != 0) e = exp_q.pop_front(); else e = 32'hFFFFFFFF;
    vecs++;
    if (pc_out !== e || instr_out !== e) begin errs++; $display("FAIL rpop_out pc=%h instr=%h want %h", pc_out, instr_out, e); end
    exp_q.delete();
    model_pc = 32'hBFC00180;
    for (int k = 0; k < 4; k++) begin
      drive(1, 1, 0, 0, 0);
      vecs++;
      if (imem_req !== 1'b1 || imem_addr !== model_pc) begin
        errs++; $display("FAIL rpop_addr k=%0d got req=%b addr=%h want 1 %h", k, imem_req, imem_addr, model_pc);
      end
      vecs++;
      if (instr_valid !== (k >= 2)) begin errs++; $display("FAIL rpop_valid k=%0d got %b want %b", k, instr_valid, (k >= 2)); end
      if (instr_valid) begin
        if (exp_q.size() != 0) e = exp_q.pop_front(); else e = 32'hFFFFFFFF;
        vecs++;
        if (pc_out !== e || instr_out !== e) begin
          errs++; $display("FAIL rpop_stream pc=%h instr=%h want %h", pc_out, instr_out, e);
        end
      end
      exp_q.push_back(model_pc);
      model_pc = model_pc + 4;
    end
  endtask

  task automatic test_misaligned();
    vecs++; if (misaligned !== 1'b0) begin errs++; $display("FAIL mis_before got %b want 0", misaligned); end
    drive(1, 1, 1, RV, 32'h00000001);
    vecs++; if (imem_req !== 1'b0) begin errs++; $display("FAIL mis_req got %b want 0", imem_req); end
    if (instr_valid) void'(exp_q.pop_front());
    exp_q.delete();
    model_pc = RV;
    for (int k = 0; k < 4; k++) begin
      drive(1, 1, 0, 0, 0);
      vecs++; if (misaligned !== 1'b1) begin errs++; $display("FAIL mis_sticky k=%0d got %b want 1", k, misaligned); end
      vecs++;
      if (imem_req !== 1'b1 || imem_addr !== model_pc) begin
        errs++; $display("FAIL mis_addr k=%0d got req=%b addr=%h want 1 %h", k, imem_req, imem_addr, model_pc);
      end
      if (instr_valid) begin
        if (exp_q.size() != 0) e = exp_q.pop_front(); else e = 32'hFFFFFFFF;
        vecs++;
        if (pc_out !== e || instr_out !== e) begin
          errs++; $display("FAIL mis_out pc=%h instr=%h want %h", pc_out, instr_out, e);
        end
      end
      exp_q.push_back(model_pc);
      model_pc = model_pc + 4;
    end
  endtask

  task automatic test_back_to_back();
    drive(1, 1, 1, RV, 32'h00000100);
    vecs++; if (imem_req !== 1'b0) begin errs++; $display("FAIL b2b_req1 got %b want 0", imem_req); end
    drive(1, 1, 1, 32'hFFFFFFF0, 32'h00000010);
    vecs++; if (imem_req !== 1'b0) begin errs++; $display("FAIL b2b_req2 got %b want 0", imem_req); end
    vecs++; if (instr_valid !== 1'b0) begin errs++; $display("FAIL b2b_flushed got %b want 0", instr_valid); end
    exp_q.delete();
    model_pc = 32'h00000010;
    for (int k = 0; k < 4; k++) begin
      drive(1, 1, 0, 0, 0);
      vecs++;
      if (imem_req !== 1'b1 || imem_addr !== model_pc) begin
        errs++; $display("FAIL b2b_addr k=%0d got req=%b addr=%h want 1 %h", k, imem_req, imem_addr, model_pc);
      end
      vecs++;
      if (instr_valid !== (k >= 2)) begin errs++; $display("FAIL b2b_valid k=%0d got %b want %b", k, instr_valid, (k >= 2)); end
      if (instr_valid) begin
        if (exp_q.size() != 0) e = exp_q.pop_front(); else e = 32'hFFFFFFFF;
        vecs++;
        if (pc_out !== e || instr_out !== e) begin
          errs++; $display("FAIL b2b_out pc=%h instr=%h want %h", pc_out, instr_out, e);
        end
      end
      exp_q.push_back(model_pc);
      model_pc = model_pc + 4;
    end
  endtask

  task automatic test_reset_mid();
    drive(1, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0);
    vecs++; if (dut.count_q !== 2'd2) begin errs++; $display("FAIL rmid_full count got %0d want 2", dut.count_q); end
    drive(0, 0, 0, 0, 0);
    vecs++; if (imem_req !== 1'b0) begin errs++; $display("FAIL rmid_req_in_reset got %b want 0", imem_req); end
    exp_q.delete();
    model_pc = RV;
    for (int k = 0; k < 6; k++) begin
      drive(1, 1, 0, 0, 0);
      if (k == 0) begin
        vecs++;
        if (pc_out !== 32'h0 || instr_out !== 32'h0 || misaligned !== 1'b0) begin
          errs++; $display("FAIL rmid_cleared got pc=%h instr=%h mis=%b want 0 0 0", pc_out, instr_out, misaligned);
        end
      end
      vecs++;
      if (imem_req !== 1'b1 || imem_addr !== model_pc) begin
        errs++; $display("FAIL rmid_addr k=%0d got req=%b addr=%h want 1 %h", k, imem_req, imem_addr, model_pc);
      end
      vecs++;
      if (instr_valid !== (k >= 2)) begin errs++; $display("FAIL rmid_valid k=%0d got %b want %b", k, instr_valid, (k >= 2)); end
      if (instr_valid) begin
        if (exp_q.size() != 0) e = exp_q.pop_front(); else e = 32'hFFFFFFFF;
        vecs++;
        if (pc_out !== e || instr_out !== e) begin
          errs++; $display("FAIL rmid_out pc=%h instr=%h want %h", pc_out, instr_out, e);
        end
      end
      exp_q.push_back(model_pc);
      model_pc = model_pc + 4;
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect();
    test_redirect_pop();
    test_misaligned();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage of the RISC-V core. Owns the program counter, issues reads to the synchronous instruction memory, and buffers returned words in a 2-entry FIFO. It presents `{pc_out, instr_out}` to decode (control unit and sign extender) over a valid/ready handshake. It accepts branch/jump redirects whose target is built from the sign extender's `ImmOp`.

## Interface
- `data_width`, 32, instruction/PC/immediate width
- `reset_vector`, 32'hBFC00000, PC loaded on reset
- `clk`  in  1  rising-edge clock
- `rst_n`  in  1  synchronous, active-low reset
- `imem_req`  out  1  read strobe to instruction memory
- `imem_addr`  out  data_width  byte address of read, valid when `imem_req`
- `imem_rdata`  in  data_width  read data, valid exactly 1 cycle after the `imem_req` cycle
- `instr_valid`  out  1  FIFO head valid
- `instr_ready`  in  1  decode accepts head this cycle
- `instr_out`  out  data_width  FIFO head instruction
- `pc_out`  out  data_width  address of `instr_out`
- `redirect`  in  1  taken branch/jump this cycle
- `redirect_base`  in  data_width  PC of the redirecting instruction
- `ImmOp`  in  data_width  sign-extended immediate, halfword units (imm[12:1])
- `misaligned`  out  1  sticky: a redirect target had bit 1 set

## Operation
- State: `pc` (next fetch address), FIFO of 2 entries `{pc, instr}`, `count` 0..2, `inflight` (1 bit), `inflight_pc`, `drop` (1 bit), `misaligned`.
- Pop: `instr_valid && instr_ready`. The head advances; `count` decrements.
- Issue condition (no redirect): `count + inflight - pop < 2`.
  - When met: `imem_req`=1, `imem_addr`=`pc`; at the edge `pc <= pc + 4`, `inflight <= 1`, `inflight_pc <= pc`.
  - Otherwise `imem_req`=0 and `inflight <= 0`.
- Return: in the cycle after an issue, if `inflight && !drop`, push `{inflight_pc, imem_rdata}` at the edge. The issue condition guarantees no overflow.
- Redirect:
  - Target = `redirect_base + {ImmOp[data_width-2:0], 1'b0}`. Full-width add, wraps modulo 2^data_width.
  - In the redirect cycle `imem_req` is forced 0.
  - At the edge: `pc <= target`, FIFO flushed (`count <= 0`), `inflight <= 0`.
  - Any response arriving for a pre-redirect request is discarded (`drop`). No push occurs that edge.
  - If `target[1]`, set `misaligned` (cleared only by reset). The redirect proceeds with `target[1:0]` forced to 00.
- Simultaneous pop and redirect: the pop completes (decode consumed the head), then the flush applies.
- Redirect while FIFO is empty or full: same behaviour. Back-to-back redirects: the last one wins, and each forces `imem_req`=0.
- No backpressure from memory. Memory latency is fixed at 1.

## Timing
- Reset values (edge with `rst_n`=0): `pc`=`reset_vector`, `count`=0, `inflight`=0, `drop`=0, `misaligned`=0. Outputs `imem_req`=0, `instr_valid`=0, `instr_out`=0, `pc_out`=0.
  - `imem_req` is also held 0 combinationally while `rst_n`=0.
  - Reset mid-operation discards FIFO contents and any in-flight response.
- First request: the first cycle with `rst_n`=1, `imem_addr`=`reset_vector`.
- Fetch latency: request in cycle N → data on `imem_rdata` in N+1 → `instr_valid` in N+2.
- Throughput: 1 instruction/cycle with `instr_ready` held 1. Steady state is `count`=1 and `inflight`=1.
- Redirect penalty: redirect in cycle R → `imem_req` for the target in R+1 → target instruction valid in R+3.
- `instr_out`/`pc_out` come from FIFO registers, with no combinational path from `imem_rdata`. `instr_out`/`pc_out` hold their value while `instr_valid && !instr_ready`.
- `imem_req` depends combinationally on `instr_ready` and `redirect`.

## Test plan
- Reset/stream: memory word = address. Release `rst_n`; `instr_ready`=1. Required: `imem_addr` BFC00000, BFC00004, … on consecutive cycles; `instr_valid` rises 2 cycles after release; `pc_out`=`instr_out`=BFC00000, BFC00004, … one per cycle.
- Backpressure: drop `instr_ready` for 5 cycles mid-stream. Required: `count` stays ≤2; `imem_req` stays low once 2 entries are held/outstanding; no address skipped or repeated after `instr_ready` returns.
- Redirect: `redirect_base`=BFC00010, `ImmOp`=FFFFFFF8 (−8 halfwords) while the FIFO is full. Required: `imem_req`=0 that cycle; next `imem_addr`=BFC00000; the in-flight response is dropped; the next `pc_out` is BFC00000, 3 cycles after the redirect.
- Redirect plus pop in the same cycle, with head `pc_out`=BFC00008: the head counts as consumed; the following valid output is the target only.
- Misaligned: `redirect_base`=BFC00000, `ImmOp`=1. Required: `misaligned`=1 persists; fetch address BFC00000 (bits[1:0] cleared).
- Reset mid-stream with the FIFO holding 2 entries: hold `rst_n`=0 for 1 cycle. Required: `instr_valid`=0; the next fetch is at BFC00000; no stale instruction is emitted.
